// File: rtl/sau_odd_pipe.sv
// rtl/sau_odd_pipe.sv - shift-add multiplier for the DCT odd-part coefficients (8/16/32 point)
// Optional rounding/saturation stage: define SAU_ODD_ROUND_EN.
module sau_odd_pipe #(
  parameter int IW    = 17,
  parameter int OW    = 27,
  parameter int TW    = 6,
  parameter int SHIFT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IW-1:0]      in_x,
  input  logic [1:0]         in_size,
  input  logic [TW-1:0]      in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [16*OW-1:0]   out_y,
  output logic [4:0]         out_nlanes,
  output logic [TW-1:0]      out_tag,
  output logic               out_err
);

  localparam int NL = 16;

  if (OW < IW + 8) begin : g_bad_ow
    $error("OW must be at least IW+8");
  end
  if (SHIFT < 1 || SHIFT > 15) begin : g_bad_shift
    $error("SHIFT must be in 1..15");
  end

  logic rdy1, rdy2;
  logic v1, v2;

  // Stage 1: sign-extend once, then build the shared odd base terms.
  logic signed [OW-1:0] xe, x3, x5, x9, x15, x31, x45;
  assign xe  = {{(OW-IW){in_x[IW-1]}}, in_x};
  assign x3  = xe + (xe <<< 1);
  assign x5  = xe + (xe <<< 2);
  assign x9  = xe + (xe <<< 3);
  assign x15 = (xe <<< 4) - xe;
  assign x31 = (xe <<< 5) - xe;
  assign x45 = (x9 <<< 2) + x9;

  logic signed [OW-1:0] b1, b3, b5, b9, b15, b31, b45;
  logic [1:0]           s1_size;
  logic [TW-1:0]        s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      b1      <= '0;
      b3      <= '0;
      b5      <= '0;
      b9      <= '0;
      b15     <= '0;
      b31     <= '0;
      b45     <= '0;
      s1_size <= '0;
      s1_tag  <= '0;
    end else begin
      if (rdy1) v1 <= in_valid;
      if (rdy1 && in_valid) begin
        b1      <= xe;
        b3      <= x3;
        b5      <= x5;
        b9      <= x9;
        b15     <= x15;
        b31     <= x31;
        b45     <= x45;
        s1_size <= in_size;
        s1_tag  <= in_tag;
      end
    end
  end

  // Stage 2 products: at most two shifted base terms per coefficient.
  logic signed [OW-1:0] c4, c9, c13, c18, c22, c25, c31, c38, c43, c46, c50, c54, c57;
  logic signed [OW-1:0] c61, c67, c70, c73, c75, c78, c80, c82, c85, c87, c88, c89, c90;
  assign c4  = b1 <<< 2;
  assign c9  = b9;
  assign c13 = b9 + (b1 <<< 2);
  assign c18 = b9 <<< 1;
  assign c22 = (b9 <<< 1) + (b1 <<< 2);
  assign c25 = (b5 <<< 2) + b5;
  assign c31 = b31;
  assign c38 = (b9 <<< 2) + (b1 <<< 1);
  assign c43 = b45 - (b1 <<< 1);
  assign c46 = b45 + b1;
  assign c50 = (b5 <<< 3) + (b5 <<< 1);
  assign c54 = (b9 <<< 2) + (b9 <<< 1);
  assign c57 = b45 + (b3 <<< 2);
  assign c61 = (b31 <<< 1) - b1;
  assign c67 = (b1 <<< 6) + b3;
  assign c70 = (b1 <<< 6) + (b3 <<< 1);
  assign c73 = (b9 <<< 3) + b1;
  assign c75 = (b15 <<< 2) + b15;
  assign c78 = (b5 <<< 4) - (b1 <<< 1);
  assign c80 = b5 <<< 4;
  assign c82 = (b5 <<< 4) + (b1 <<< 1);
  assign c85 = (b5 <<< 4) + b5;
  assign c87 = (b45 <<< 1) - b3;
  assign c88 = (b45 <<< 1) - (b1 <<< 1);
  assign c89 = (b45 <<< 1) - b1;
  assign c90 = b45 <<< 1;

  logic signed [OW-1:0] lane [NL];
  logic [NL*OW-1:0]     lanes;
  logic [4:0]           nl;

  always_comb begin
    for (int k = 0; k < NL; k++) lane[k] = '0;
    nl = 5'd0;
    case (s1_size)
      2'd0: begin
        nl = 5'd4;
        lane[0] = c89; lane[1] = c75; lane[2] = c50; lane[3] = c18;
      end
      2'd1: begin
        nl = 5'd8;
        lane[0] = c90; lane[1] = c87; lane[2] = c80; lane[3] = c70;
        lane[4] = c57; lane[5] = c43; lane[6] = c25; lane[7] = c9;
      end
      2'd2: begin
        nl = 5'd16;
        lane[0]  = c90; lane[1]  = c90; lane[2]  = c88; lane[3]  = c85;
        lane[4]  = c82; lane[5]  = c78; lane[6]  = c73; lane[7]  = c67;
        lane[8]  = c61; lane[9]  = c54; lane[10] = c46; lane[11] = c38;
        lane[12] = c31; lane[13] = c22; lane[14] = c13; lane[15] = c4;
      end
      default: ;
    endcase
    lanes = '0;
    for (int k = 0; k < NL; k++) lanes[k*OW +: OW] = lane[k];
  end

  logic [NL*OW-1:0] y2;
  logic [4:0]       nl2;
  logic [TW-1:0]    tag2;
  logic             err2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      y2   <= '0;
      nl2  <= '0;
      tag2 <= '0;
      err2 <= 1'b0;
    end else begin
      if (rdy2) v2 <= v1;
      if (rdy2 && v1) begin
        y2   <= lanes;
        nl2  <= nl;
        tag2 <= s1_tag;
        err2 <= (s1_size == 2'd3);
      end
    end
  end

  assign rdy1     = !v1 || rdy2;
  assign in_ready = rdy1;

`ifdef SAU_ODD_ROUND_EN
  localparam logic signed [OW:0] HALF = (OW+1)'(1) << (SHIFT - 1);
  localparam logic signed [OW:0] MAXV = {2'b00, {(OW-1){1'b1}}};
  localparam logic signed [OW:0] MINV = {2'b11, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] round_sat(input logic [OW-1:0] p);
    logic signed [OW:0] t;
    t = $signed({p[OW-1], p}) + HALF;
    t = t >>> SHIFT;
    if (t > MAXV)      t = MAXV;
    else if (t < MINV) t = MINV;
    return t[OW-1:0];
  endfunction

  logic [NL*OW-1:0] yr;
  always_comb begin
    yr = '0;
    for (int k = 0; k < NL; k++) yr[k*OW +: OW] = round_sat(y2[k*OW +: OW]);
  end

  logic             rdy3, v3, err3;
  logic [NL*OW-1:0] y3;
  logic [4:0]       nl3;
  logic [TW-1:0]    tag3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      y3   <= '0;
      nl3  <= '0;
      tag3 <= '0;
      err3 <= 1'b0;
    end else begin
      if (rdy3) v3 <= v2;
      if (rdy3 && v2) begin
        y3   <= yr;
        nl3  <= nl2;
        tag3 <= tag2;
        err3 <= err2;
      end
    end
  end

  assign rdy3       = !v3 || out_ready;
  assign rdy2       = !v2 || rdy3;
  assign out_valid  = v3;
  assign out_y      = y3;
  assign out_nlanes = nl3;
  assign out_tag    = tag3;
  assign out_err    = err3;
`else
  assign rdy2       = !v2 || out_ready;
  assign out_valid  = v2;
  assign out_y      = y2;
  assign out_nlanes = nl2;
  assign out_tag    = tag2;
  assign out_err    = err2;
`endif

endmodule

// File: tb/tb_sau_odd_pipe.sv
// tb/tb_sau_odd_pipe.sv - directed self-checking bench for sau_odd_pipe
module tb_sau_odd_pipe;
  localparam int IW = 17, OW = 27, TW = 6, SHIFT = 7;
`ifdef SAU_ODD_ROUND_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IW-1:0]    in_x = '0;
  logic [1:0]       in_size = '0;
  logic [TW-1:0]    in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [16*OW-1:0] out_y;
  logic [4:0]       out_nlanes;
  logic [TW-1:0]    out_tag;
  logic             out_err;

  sau_odd_pipe #(.IW(IW), .OW(OW), .TW(TW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_size(in_size), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_nlanes(out_nlanes), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint lane(input int k);
    return longint'($signed(out_y[k*OW +: OW]));
  endfunction

  function automatic longint coef(input int sz, input int k);
    int t0[4];
    int t1[8];
    int t2[16];
    t0 = '{89, 75, 50, 18};
    t1 = '{90, 87, 80, 70, 57, 43, 25, 9};
    t2 = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    case (sz)
      0: return (k < 4) ? longint'(t0[k]) : 0;
      1: return (k < 8) ? longint'(t1[k]) : 0;
      2: return longint'(t2[k]);
      default: return 0;
    endcase
  endfunction

  function automatic longint expv(input longint x, input int sz, input int k);
    longint p;
    p = x * coef(sz, k);
`ifdef SAU_ODD_ROUND_EN
    p = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`endif
    return p;
  endfunction

  typedef struct { longint x; int sz; int tag; } ent_t;
  ent_t exp_q[$];

  int               n_acc = 0, n_valid = 0, run = 0, run_max = 0;
  logic             prev_stall = 1'b0;
  logic [16*OW-1:0] prev_y;
  logic [TW-1:0]    prev_tag;
  logic [4:0]       prev_nl;
  logic             prev_err;

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      run = 0;
    end else begin
      if (prev_stall) begin
        chk("hold valid", out_valid, 1);
        chk("hold y", longint'(out_y == prev_y), 1);
        chk("hold tag", out_tag, prev_tag);
        chk("hold nlanes", out_nlanes, prev_nl);
        chk("hold err", out_err, prev_err);
      end
      prev_stall = out_valid && !out_ready;
      prev_y = out_y; prev_tag = out_tag; prev_nl = out_nlanes; prev_err = out_err;
      if (out_valid) n_valid++;
      if (out_valid && out_ready) begin
        run++;
        if (run > run_max) run_max = run;
        if (exp_q.size() == 0) begin
          chk("spurious output", 1, 0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("out tag", out_tag, e.tag);
          chk("out nlanes", out_nlanes, (e.sz == 0) ? 4 : (e.sz == 1) ? 8 : (e.sz == 2) ? 16 : 0);
          chk("out err", out_err, longint'(e.sz == 3));
          for (int k = 0; k < 16; k++) chk($sformatf("lane%0d", k), lane(k), expv(e.x, e.sz, k));
        end
      end else begin
        run = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{longint'($signed(in_x)), int'(in_size), int'(in_tag)});
        n_acc++;
      end
    end
  end

  task automatic send(input longint x, input int sz, input int tag);
    int n;
    in_x = IW'(x); in_size = 2'(sz); in_tag = TW'(tag); in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
    chk("queue drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, nv;
    int e1[16];
    logic [31:0] pat;
    e1 = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    pat = 32'hB3C5_96E1;

    // Reset state
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_y zero", longint'(out_y == '0), 1);
    chk("rst out_tag", out_tag, 0);
    chk("rst out_nlanes", out_nlanes, 0);
    chk("rst out_err", out_err, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready", in_ready, 1);

    // x=1, size 2: latency and full coefficient set
    send(1, 2, 5);
    chk("lat not early", out_valid, 0);
`ifdef SAU_ODD_ROUND_EN
    @(posedge clk); #1;
    chk("lat not early 2", out_valid, 0);
`endif
    @(posedge clk); #1;
    chk("lat valid", out_valid, 1);
    chk("t1 tag", out_tag, 5);
    chk("t1 nlanes", out_nlanes, 16);
`ifndef SAU_ODD_ROUND_EN
    for (int k = 0; k < 16; k++) chk($sformatf("t1 lane%0d", k), lane(k), e1[k]);
`endif
    drain();

    // Most negative input, size 0
    send(-65536, 0, 9);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("t2 nlanes", out_nlanes, 4);
`ifndef SAU_ODD_ROUND_EN
    chk("t2 lane0", lane(0), -5832704);
    chk("t2 lane1", lane(1), -4915200);
    chk("t2 lane2", lane(2), -3276800);
    chk("t2 lane3", lane(3), -1179648);
`endif
    for (int k = 4; k < 16; k++) chk($sformatf("t2 lane%0d", k), lane(k), 0);
    drain();

    // Back-to-back sizes 0..3
    run_max = 0;
    send(3, 0, 10);
    send(-7, 1, 11);
    send(12345, 2, 12);
    send(777, 3, 13);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("b2b err", out_err, 1);
    chk("b2b err nlanes", out_nlanes, 0);
    chk("b2b err y zero", longint'(out_y == '0), 1);
    chk("b2b err tag", out_tag, 13);
    drain();
    chk("b2b consecutive", run_max, 4);

    // Backpressure: 5 stalled cycles while offering 4 samples
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(100, 1, 20);
        send(-200, 2, 21);
        send(300, 0, 22);
        send(-400, 1, 23);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall in_ready", in_ready, 0);
        chk("stall accepts", n_acc - base, LAT);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with samples in flight
    send(11, 1, 30);
    send(22, 2, 31);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst in_ready", in_ready, 1);
    chk("mid-rst out_y zero", longint'(out_y == '0), 1);
    exp_q.delete();
    nv = n_valid;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no output after rst", n_valid - nv, 0);

`ifdef SAU_ODD_ROUND_EN
    send(100, 1, 40);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("round +100 lane0", lane(0), 70);
    send(-100, 1, 41);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("round -100 lane0", lane(0), -70);
    drain();
`endif

    // Mixed stream under a fixed backpressure pattern
    fork
      begin
        for (int i = 0; i < 24; i++) send(longint'((i * 7919) % 131071) - 65535, i % 4, i);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          out_ready = pat[c % 32];
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
